// File: rtl/decode_rename.sv
// Two-wide RV32I decode plus register rename against a 64-entry physical file.
// Optional macro PREG_RELEASE_EN adds a port that returns pregs to the free pool.
module decode_rename (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr_1,
  input  logic [31:0] instr_2,
  output logic [4:0]  dec_rs1_1,
  output logic [4:0]  dec_rs2_1,
  output logic [4:0]  dec_rd_1,
  output logic [4:0]  dec_rs1_2,
  output logic [4:0]  dec_rs2_2,
  output logic [4:0]  dec_rd_2,
  output logic        out_valid,
  output logic [6:0]  opcode_1,
  output logic [6:0]  opcode_2,
  output logic [2:0]  func3_1,
  output logic [2:0]  func3_2,
  output logic [6:0]  func7_1,
  output logic [6:0]  func7_2,
  output logic [31:0] instr_out_1,
  output logic [31:0] instr_out_2,
  output logic [5:0]  ps1_1,
  output logic [5:0]  ps2_1,
  output logic [5:0]  pd_1,
  output logic [5:0]  ps1_2,
  output logic [5:0]  ps2_2,
  output logic [5:0]  pd_2
`ifdef PREG_RELEASE_EN
  ,
  input  logic        free_valid,
  input  logic [5:0]  free_preg
`endif
);

  localparam int NUM_AREGS = 32;
  localparam int NUM_PREGS = 64;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [31:0] instr;
    logic [5:0]  ps1;
    logic [5:0]  ps2;
    logic [5:0]  pd;
  } slot_out_t;

  function automatic logic writes_rd(input logic [31:0] instr);
    logic op_ok;
    case (instr[6:0])
      7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: op_ok = 1'b1;
      default:                            op_ok = 1'b0;
    endcase
    return op_ok && (instr[11:7] != 5'd0);
  endfunction

  assign dec_rs1_1 = instr_1[19:15];
  assign dec_rs2_1 = instr_1[24:20];
  assign dec_rd_1  = instr_1[11:7];
  assign dec_rs1_2 = instr_2[19:15];
  assign dec_rs2_2 = instr_2[24:20];
  assign dec_rd_2  = instr_2[11:7];

  logic                 s1_valid_q, s1_valid_d;
  logic [31:0]          s1_instr_1_q, s1_instr_1_d;
  logic [31:0]          s1_instr_2_q, s1_instr_2_d;
  logic [5:0]           rat_q [NUM_AREGS];
  logic [5:0]           rat_d [NUM_AREGS];
  logic [NUM_PREGS-1:0] free_q, free_d;
  logic                 out_valid_q, out_valid_d;
  slot_out_t            out_1_q, out_1_d;
  slot_out_t            out_2_q, out_2_d;

  logic       wr_1, wr_2, stall, commit;
  logic [6:0] free_cnt, n_need;
  logic [5:0] first_free, second_free, new_pd_1, new_pd_2;
  logic [4:0] rd_1, rd_2, rs1_2, rs2_2;

  assign wr_1  = s1_valid_q && writes_rd(s1_instr_1_q);
  assign wr_2  = s1_valid_q && writes_rd(s1_instr_2_q);
  assign rd_1  = s1_instr_1_q[11:7];
  assign rd_2  = s1_instr_2_q[11:7];
  assign rs1_2 = s1_instr_2_q[19:15];
  assign rs2_2 = s1_instr_2_q[24:20];

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so the loops below never infer a latch.
  always_comb begin
    free_cnt    = '0;
    first_free  = '0;
    second_free = '0;
    for (int i = NUM_PREGS - 1; i >= 1; i--) begin
      free_cnt = free_cnt + 7'(free_q[i]);
      if (free_q[i]) first_free = 6'(i);
    end
    for (int i = NUM_PREGS - 1; i >= 1; i--) begin
      if (free_q[i] && (6'(i) != first_free)) second_free = 6'(i);
    end
  end

  assign n_need   = 7'(wr_1) + 7'(wr_2);
  assign stall    = s1_valid_q && (free_cnt < n_need);
  assign commit   = s1_valid_q && !stall;
  assign in_ready = !stall;
  assign new_pd_1 = wr_1 ? first_free : 6'd0;
  assign new_pd_2 = wr_2 ? (wr_1 ? second_free : first_free) : 6'd0;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_instr_1_d = s1_instr_1_q;
    s1_instr_2_d = s1_instr_2_q;
    if (in_valid && in_ready) begin
      s1_valid_d   = 1'b1;
      s1_instr_1_d = instr_1;
      s1_instr_2_d = instr_2;
    end else if (commit) begin
      s1_valid_d = 1'b0;
    end
  end

  // Slot 2 sees slot 1's new mapping when it reads the register slot 1 writes.
  always_comb begin
    out_valid_d = commit;
    out_1_d     = out_1_q;
    out_2_d     = out_2_q;
    if (commit) begin
      out_1_d.opcode = s1_instr_1_q[6:0];
      out_1_d.func3  = s1_instr_1_q[14:12];
      out_1_d.func7  = s1_instr_1_q[31:25];
      out_1_d.instr  = s1_instr_1_q;
      out_1_d.ps1    = rat_q[s1_instr_1_q[19:15]];
      out_1_d.ps2    = rat_q[s1_instr_1_q[24:20]];
      out_1_d.pd     = new_pd_1;
      out_2_d.opcode = s1_instr_2_q[6:0];
      out_2_d.func3  = s1_instr_2_q[14:12];
      out_2_d.func7  = s1_instr_2_q[31:25];
      out_2_d.instr  = s1_instr_2_q;
      out_2_d.ps1    = (wr_1 && rs1_2 == rd_1) ? new_pd_1 : rat_q[rs1_2];
      out_2_d.ps2    = (wr_1 && rs2_2 == rd_1) ? new_pd_1 : rat_q[rs2_2];
      out_2_d.pd     = new_pd_2;
    end
  end

  always_comb begin
    rat_d  = rat_q;
    free_d = free_q;
`ifdef PREG_RELEASE_EN
    if (free_valid && (free_preg != 6'd0)) free_d[free_preg] = 1'b1;
`endif
    if (commit) begin
      if (wr_1) begin
        free_d[new_pd_1] = 1'b0;
        rat_d[rd_1]      = new_pd_1;
      end
      if (wr_2) begin
        free_d[new_pd_2] = 1'b0;
        rat_d[rd_2]      = new_pd_2;
      end
    end
  end

  // NOTE: the RAT and free pool are architectural state and must come out of
  // reset known (identity map, upper half free), so unlike a data RAM they are reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_instr_1_q <= '0;
      s1_instr_2_q <= '0;
      free_q       <= {32'hFFFF_FFFF, 32'h0000_0000};
      for (int i = 0; i < NUM_AREGS; i++) rat_q[i] <= 6'(i);
      out_valid_q  <= 1'b0;
      out_1_q      <= '0;
      out_2_q      <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_instr_1_q <= s1_instr_1_d;
      s1_instr_2_q <= s1_instr_2_d;
      free_q       <= free_d;
      rat_q        <= rat_d;
      out_valid_q  <= out_valid_d;
      out_1_q      <= out_1_d;
      out_2_q      <= out_2_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign opcode_1    = out_1_q.opcode;
  assign func3_1     = out_1_q.func3;
  assign func7_1     = out_1_q.func7;
  assign instr_out_1 = out_1_q.instr;
  assign ps1_1       = out_1_q.ps1;
  assign ps2_1       = out_1_q.ps2;
  assign pd_1        = out_1_q.pd;
  assign opcode_2    = out_2_q.opcode;
  assign func3_2     = out_2_q.func3;
  assign func7_2     = out_2_q.func7;
  assign instr_out_2 = out_2_q.instr;
  assign ps1_2       = out_2_q.ps1;
  assign ps2_2       = out_2_q.ps2;
  assign pd_2        = out_2_q.pd;

endmodule

// File: tb/tb_decode_rename.sv
// Self-checking bench for decode_rename: directed vector table, corner sequences,
// and random bundles checked against a sequential rename model.
module tb_decode_rename;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_1 = '0, instr_2 = '0;
  logic [4:0]  dec_rs1_1, dec_rs2_1, dec_rd_1, dec_rs1_2, dec_rs2_2, dec_rd_2;
  logic        out_valid;
  logic [6:0]  opcode_1, opcode_2, func7_1, func7_2;
  logic [2:0]  func3_1, func3_2;
  logic [31:0] instr_out_1, instr_out_2;
  logic [5:0]  ps1_1, ps2_1, pd_1, ps1_2, ps2_2, pd_2;
`ifdef PREG_RELEASE_EN
  logic        free_valid = 1'b0;
  logic [5:0]  free_preg = '0;
`endif

  always #5 clk = ~clk;

  decode_rename dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_1(instr_1), .instr_2(instr_2),
    .dec_rs1_1(dec_rs1_1), .dec_rs2_1(dec_rs2_1), .dec_rd_1(dec_rd_1),
    .dec_rs1_2(dec_rs1_2), .dec_rs2_2(dec_rs2_2), .dec_rd_2(dec_rd_2),
    .out_valid(out_valid),
    .opcode_1(opcode_1), .opcode_2(opcode_2), .func3_1(func3_1), .func3_2(func3_2),
    .func7_1(func7_1), .func7_2(func7_2),
    .instr_out_1(instr_out_1), .instr_out_2(instr_out_2),
    .ps1_1(ps1_1), .ps2_1(ps2_1), .pd_1(pd_1),
    .ps1_2(ps1_2), .ps2_2(ps2_2), .pd_2(pd_2)
`ifdef PREG_RELEASE_EN
    , .free_valid(free_valid), .free_preg(free_preg)
`endif
  );

  typedef struct {
    logic [31:0] i1, i2;
    int          ps1_1, ps2_1, pd_1, ps1_2, ps2_2, pd_2;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: rename slot 1 then slot 2 in program order.
  int m_rat [32];
  bit m_free [64];

  function automatic bit m_writes(input logic [31:0] i);
    logic [6:0] op;
    op = i[6:0];
    return (op == 7'h33 || op == 7'h13 || op == 7'h03 || op == 7'h37 ||
            op == 7'h17 || op == 7'h6F || op == 7'h67) && (i[11:7] != 0);
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) m_rat[r] = r;
    for (int p = 0; p < 64; p++) m_free[p] = (p >= 32);
  endtask

  function automatic int model_free_count();
    int c = 0;
    for (int p = 1; p < 64; p++) if (m_free[p]) c++;
    return c;
  endfunction

  task automatic model_slot(input logic [31:0] i, output int ps1, output int ps2, output int pd);
    ps1 = m_rat[i[19:15]];
    ps2 = m_rat[i[24:20]];
    pd  = 0;
    if (m_writes(i)) begin
      for (int p = 1; p < 64; p++) if (m_free[p] && pd == 0) pd = p;
      m_free[pd] = 0;
      m_rat[i[11:7]] = pd;
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".ps1_1"}, 32'(ps1_1), 32'(v.ps1_1));
    check({tag, ".ps2_1"}, 32'(ps2_1), 32'(v.ps2_1));
    check({tag, ".pd_1"},  32'(pd_1),  32'(v.pd_1));
    check({tag, ".ps1_2"}, 32'(ps1_2), 32'(v.ps1_2));
    check({tag, ".ps2_2"}, 32'(ps2_2), 32'(v.ps2_2));
    check({tag, ".pd_2"},  32'(pd_2),  32'(v.pd_2));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Single bundle from idle: exact two-cycle latency and a one-cycle out_valid pulse.
  task automatic run_bundle(input string tag, input vec_t v);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; instr_1 = v.i1; instr_2 = v.i2;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".out_valid_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check_outputs(tag, v);
    check({tag, ".instr_out_1"}, instr_out_1, v.i1);
    check({tag, ".instr_out_2"}, instr_out_2, v.i2);
    check({tag, ".opcode_2"}, 32'(opcode_2), 32'(v.i2[6:0]));
    check({tag, ".func3_1"},  32'(func3_1),  32'(v.i1[14:12]));
    check({tag, ".func7_1"},  32'(func7_1),  32'(v.i1[31:25]));
    @(negedge clk);
    check({tag, ".out_valid_pulse"}, 32'(out_valid), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11];
    ops = '{7'h33, 7'h13, 7'h03, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h23, 7'h63, 7'h00, 7'h7F};
    return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            3'($urandom), 5'($urandom_range(0, 7)), ops[$urandom_range(0, 10)]};
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t table_v [9];
    vec_t v;
    vec_t q [$];
    int accepted, emitted, waited;

    table_v[0] = '{32'h002081B3, 32'h00118233,  1, 2, 32, 32, 1, 33};
    table_v[1] = '{32'h0020A023, 32'h002081B3,  1, 2,  0,  1, 2, 32};
    table_v[2] = '{32'h00208033, 32'h002081B3,  1, 2,  0,  1, 2, 32};
    table_v[3] = '{32'h00208033, 32'h000002B3,  1, 2,  0,  0, 0, 32};
    table_v[4] = '{32'h00508393, 32'h123453B7,  1, 5, 32,  8, 3, 33};
    table_v[5] = '{32'h002081B3, 32'h003184B3,  1, 2, 32, 32, 32, 33};
    table_v[6] = '{32'h00208063, 32'h000000EF,  1, 2,  0,  0, 0, 32};
    table_v[7] = '{32'h0020A223, 32'h000202B3,  1, 2,  0,  4, 0, 32};
    table_v[8] = '{32'h000001FF, 32'h00018333,  0, 0,  0,  3, 0, 32};

    // Reset state and combinational decode
    do_reset();
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.pd_1",      32'(pd_1),      32'd0);
    check("rst.instr_out_2", instr_out_2,  32'd0);
    instr_1 = 32'h002081B3; instr_2 = 32'h00118233;
    #1;
    check("dec_rs1_1", 32'(dec_rs1_1), 32'd1);
    check("dec_rs2_1", 32'(dec_rs2_1), 32'd2);
    check("dec_rd_1",  32'(dec_rd_1),  32'd3);
    check("dec_rs1_2", 32'(dec_rs1_2), 32'd3);
    check("dec_rs2_2", 32'(dec_rs2_2), 32'd1);
    check("dec_rd_2",  32'(dec_rd_2),  32'd4);

    for (int k = 0; k < 9; k++) begin
      do_reset();
      run_bundle($sformatf("vec%0d", k), table_v[k]);
    end

    // RAT[3] follows the store/add bundle
    do_reset();
    run_bundle("st_add", table_v[1]);
    v = '{32'h00118233, 32'h00000013, 32, 1, 33, 0, 0, 0};
    run_bundle("st_add_follow", v);

    // Exhaust the pool: 16 two-writer bundles, the 17th stalls
    do_reset();
    accepted = 0; emitted = 0;
    for (int cyc = 0; cyc < 200 && accepted < 17; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        v = '{0, 0, 1, 2, 32 + 2 * emitted, 32 + 2 * emitted, 1, 33 + 2 * emitted};
        check($sformatf("exh%0d", emitted), 32'(emitted < 16), 32'd1);
        check_outputs($sformatf("exh%0d", emitted), v);
        emitted++;
      end
      in_valid = 1'b1; instr_1 = 32'h002081B3; instr_2 = 32'h00118233;
      #1;
      if (in_ready) accepted++;
    end
    check("exh.accepted", 32'(accepted), 32'd17);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        v = '{0, 0, 1, 2, 32 + 2 * emitted, 32 + 2 * emitted, 1, 33 + 2 * emitted};
        check_outputs($sformatf("exh%0d", emitted), v);
        emitted++;
      end
    end
    check("exh.emitted",   32'(emitted),   32'd16);
    check("exh.in_ready",  32'(in_ready),  32'd0);
    check("exh.out_valid", 32'(out_valid), 32'd0);
`ifdef PREG_RELEASE_EN
    free_valid = 1'b1; free_preg = 6'd40;
    @(negedge clk);
    free_preg = 6'd41;
    check("rel.still_stalled", 32'(in_ready), 32'd0);
    @(negedge clk);
    free_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    check("rel.out_valid", 32'(out_valid), 32'd1);
    v = '{0, 0, 1, 2, 40, 40, 1, 41};
    check_outputs("rel", v);
`endif

    // Asynchronous reset with one bundle on the output and one in stage 1
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; instr_1 = 32'h002081B3; instr_2 = 32'h00118233;
    @(negedge clk);
    instr_1 = 32'h0020A023; instr_2 = 32'h002081B3;
    @(negedge clk);
    in_valid = 1'b0;
    check("arst.pre_out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst.out_valid_now", 32'(out_valid), 32'd0);
    check("arst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    waited = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (out_valid) waited++;
    end
    check("arst.no_emit", 32'(waited), 32'd0);
    run_bundle("arst.identity", table_v[0]);

    // Random bundles against the reference model
    do_reset();
    model_reset();
    emitted = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        check("rnd.unexpected_out", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          v = q.pop_front();
          model_slot(v.i1, v.ps1_1, v.ps2_1, v.pd_1);
          model_slot(v.i2, v.ps1_2, v.ps2_2, v.pd_2);
          check_outputs($sformatf("rnd%0d", emitted), v);
          emitted++;
        end
      end
      if (cyc < 60 && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1; instr_1 = rand_instr(); instr_2 = rand_instr();
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_valid && in_ready) begin
        v = '{instr_1, instr_2, 0, 0, 0, 0, 0, 0};
        q.push_back(v);
      end
    end
    in_valid = 1'b0;
    check("rnd.pending", 32'(q.size() <= 1), 32'd1);
    if (q.size() == 1)
      check("rnd.final_in_ready", 32'(in_ready),
            32'(model_free_count() >= int'(m_writes(q[0].i1)) + int'(m_writes(q[0].i2))));
    else
      check("rnd.final_in_ready", 32'(in_ready), 32'd1);
    check("rnd.some_emitted", 32'(emitted > 3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_rename.md
Name: decode_rename

Overview:
- Two-wide front-end block for the out-of-order RISC-V core. It sits between instruction fetch and dispatch.
- Decodes two 32-bit RV32I instructions per cycle into fields.
- Registers the fields in a decode-to-rename pipeline stage.
- Renames architectural registers to 64 physical registers using a RAT and a free pool.
- Both RAT and free pool are held inside the block.

Parameters:
- NUM_AREGS, 32, architectural registers; fixed, sets the 5-bit index width.
- NUM_PREGS, 64, physical registers; fixed, sets the 6-bit index width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instr_1/instr_2 bundle valid.
- in_ready  out  1  block accepts a bundle this cycle.
- instr_1, instr_2  in  32 each  fetched instructions (slot 1 is older).
- dec_rs1_1, dec_rs2_1, dec_rd_1, dec_rs1_2, dec_rs2_2, dec_rd_2  out  5 each  combinational decode of the inputs.
- out_valid  out  1  renamed bundle valid.
- opcode_1/_2  out  7  registered.
- func3_1/_2  out  3  registered.
- func7_1/_2  out  7  registered.
- instr_out_1/_2  out  32  registered instruction passthrough.
- ps1_1, ps2_1, pd_1, ps1_2, ps2_2, pd_2  out  6 each  physical source/destination registers.
- free_valid, free_preg  in  1, 6  release port; present only with PREG_RELEASE_EN.

Behaviour:
- Decode (combinational) fields:
  - opcode = [6:0], rd = [11:7], func3 = [14:12].
  - rs1 = [19:15], rs2 = [24:20], func7 = [31:25].
- Stage 1, decode-to-rename register:
  - Captures the decoded fields, instr and in_valid when in_valid && in_ready.
  - Holds its contents while in_ready = 0.
  - Loads valid = 0 when no bundle is accepted and the rename stage consumed its contents.
- Stage 2, rename, registered outputs; total latency from input to output is 2 cycles.
- writes_rd is true when opcode is one of 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111, and rd != 0.
  - Stores, branches, opcode 0 and unknown opcodes do not write rd.
- Source renaming:
  - ps1 = RAT[rs1], ps2 = RAT[rs2], always looked up.
  - Slot 2 bypass: if slot 1 writes_rd and rs1_2 == rd_1, then ps1_2 = pd_1; likewise for rs2_2.
- Allocation:
  - Slot 1 gets the lowest-numbered free preg; slot 2 gets the next lowest.
  - If only slot 2 writes, slot 2 gets the lowest.
  - A non-writing slot outputs pd = 0 and allocates nothing.
- Commit of a bundle:
  - The free-pool bit of each allocated preg is set to busy.
  - RAT[rd] is updated to the new pd; slot 2 wins if rd_1 == rd_2.
  - out_valid = 1 for one cycle.
- Stall: if stage 1 is valid and free count < number of writing slots:
  - No allocation, no RAT change, out_valid = 0.
  - Stage 1 holds; in_ready = 0.
  - Otherwise in_ready = 1.
- Allocation decisions use start-of-cycle free-pool state.
- Reset values:
  - RAT[n] = n.
  - Pregs 0-31 busy; pregs 32-63 free.
  - Stage 1 cleared.
  - All outputs 0, including out_valid = 0.
  - in_ready = 1 after reset.
- Reset asserted mid-operation discards in-flight bundles immediately.
- RAT[0] always maps to p0; p0 is never allocated or released.

Optional Feature:
- Macro PREG_RELEASE_EN.
- Defined:
  - Adds free_valid/free_preg.
  - When free_valid = 1 and free_preg != 0, the preg is marked free at the clock edge.
  - The freed preg is allocatable from the next cycle.
  - Releasing p0 is ignored.
- Undefined:
  - Ports absent; pregs never return to the pool.
  - The block stalls permanently once 32 allocations are exhausted.

Test Plan:
- After reset, instr_1 = 0x002081B3 (add x3,x1,x2), instr_2 = 0x00118233 (add x4,x3,x1), in_valid = 1 -> 2 cycles later, out_valid = 1 with:
  - slot 1: ps1 = 1, ps2 = 2, pd = 32.
  - slot 2: ps1 = 32, ps2 = 1, pd = 33.
- Same bundle, checking combinational decode -> dec_rs1_1 = 1, dec_rs2_1 = 2, dec_rd_1 = 3, dec_rd_2 = 4 in the same cycle.
- instr_1 = 0x0020A023 (sw x2,0(x1)), instr_2 = 0x002081B3 from reset -> pd_1 = 0, ps1_1 = 1, ps2_1 = 2; pd_2 = 32; RAT[3] = 32 afterward.
- Slot 1 with rd = x0 (0x00208033) -> pd_1 = 0, no allocation; slot 2 add allocates p32.
- 16 consecutive two-writer bundles allocating p32..p63, then a 17th two-writer bundle -> 17th bundle stalls:
  - in_ready = 0 and out_valid = 0.
  - RAT unchanged.
  - With PREG_RELEASE_EN, release p40 then p41 -> stalled bundle emits pd_1 = 40, pd_2 = 41.
- Assert rst asynchronously while a bundle is in stage 1 -> out_valid drops at once, no bundle is emitted, RAT returns to identity.
